// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
//   Shared definitions for the restoring divider: FSM state encoding, the
//   width of the external state port, and the quotient bit value used when
//   the divisor is zero.
// -----------------------------------------------------------------------------
package div_pkg;

  localparam int STATE_W     = 2;  // bits needed for the three FSM states
  localparam int STATE_OUT_W = 4;  // width of the externally visible state port

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    DONE = 2'd2
  } state_e;

  // Divide-by-zero result: every quotient bit is set (all-ones quotient).
  localparam logic DBZ_Q_BIT = 1'b1;

  // Zero-extend the internal state encoding onto the external port.
  function automatic logic [STATE_OUT_W-1:0] state_code(input state_e s);
    return {{(STATE_OUT_W-STATE_W){1'b0}}, s};
  endfunction

endpackage

// File: rtl/div_controller.sv
// -----------------------------------------------------------------------------
// div_controller
//   Sequencer for the restoring divider: three-state FSM plus the step
//   counter that counts the WIDTH shift/subtract iterations.
//
//   clk        rising-edge clock
//   rst        synchronous active-low reset
//   ena        start request, only honoured in IDLE
//   b_zero     divisor presented on the start cycle is zero
//   state      current FSM state
//   last_step  high in the final STEP cycle (counter has reached 0)
// -----------------------------------------------------------------------------
module div_controller
  import div_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   ena,
  input  logic   b_zero,
  output state_e state,
  output logic   last_step
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (ena) begin
          if (b_zero) begin
            state_d = DONE;  // no iterations needed, result is fixed
          end else begin
            state_d = STEP;
            cnt_d   = CNT_W'(WIDTH - 1);
          end
        end
      end
      STEP: begin
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign state     = state_q;
  assign last_step = (state_q == STEP) && (cnt_q == '0);

endmodule

// File: rtl/four_bit_divider.sv
// -----------------------------------------------------------------------------
// four_bit_divider
//   Multi-cycle unsigned restoring divider, one quotient bit per clock,
//   MSB first. A start with a zero divisor completes immediately with an
//   all-ones quotient, the dividend as remainder, and div_by_zero set.
//
//   clk          rising-edge clock
//   rst          synchronous active-low reset (priority over ena)
//   ena          start request, sampled only while idle
//   A, B         dividend / divisor, captured on the start edge
//   Q, R         quotient / remainder, held until the next result
//   done         one-cycle result-valid strobe
//   div_by_zero  error flag belonging to the current result
//   busy         high while a division is in progress or completing
//   state        current FSM state, zero-extended
// -----------------------------------------------------------------------------
module four_bit_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ena,
  input  logic [WIDTH-1:0]       A,
  input  logic [WIDTH-1:0]       B,
  output logic [WIDTH-1:0]       Q,
  output logic [WIDTH-1:0]       R,
  output logic                   done,
  output logic                   div_by_zero,
  output logic                   busy,
  output logic [STATE_OUT_W-1:0] state
);

  state_e fsm_state;
  logic   last_step;
  logic   b_zero;
  logic   start;

  assign b_zero = (B == '0);
  assign start  = (fsm_state == IDLE) && ena;

  div_controller #(
    .WIDTH (WIDTH)
  ) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .b_zero    (b_zero),
    .state     (fsm_state),
    .last_step (last_step)
  );

  // Operand copies let A/B change freely once the division has started.
  logic [WIDTH-1:0] dividend_q;
  logic [WIDTH-1:0] divisor_q;
  logic [WIDTH:0]   partial_q;  // one spare bit so compare/subtract never wraps
  logic [WIDTH-1:0] quot_q;

  // One restoring step: bring in the next dividend bit, trial-subtract.
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   divisor_ext;
  logic             fits;
  logic [WIDTH:0]   partial_next;
  logic [WIDTH-1:0] quot_next;

  assign divisor_ext  = {1'b0, divisor_q};
  assign trial        = (partial_q << 1) | {{WIDTH{1'b0}}, dividend_q[WIDTH-1]};
  assign fits         = (trial >= divisor_ext);
  assign partial_next = fits ? (trial - divisor_ext) : trial;
  assign quot_next    = {quot_q[WIDTH-2:0], fits};

  always_ff @(posedge clk) begin
    if (!rst) begin
      dividend_q  <= '0;
      divisor_q   <= '0;
      partial_q   <= '0;
      quot_q      <= '0;
      Q           <= '0;
      R           <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      busy        <= 1'b0;
    end else begin
      done <= 1'b0;
      // Busy covers STEP and DONE: set on start, kept through STEP, and
      // dropped on the DONE->IDLE edge.
      busy <= start || (fsm_state == STEP);

      if (start) begin
        dividend_q <= A;
        divisor_q  <= B;
        partial_q  <= '0;
        quot_q     <= '0;
        if (b_zero) begin
          Q           <= {WIDTH{DBZ_Q_BIT}};
          R           <= A;
          div_by_zero <= 1'b1;
          done        <= 1'b1;
        end else begin
          div_by_zero <= 1'b0;
        end
      end else if (fsm_state == STEP) begin
        dividend_q <= dividend_q << 1;
        partial_q  <= partial_next;
        quot_q     <= quot_next;
        if (last_step) begin
          Q    <= quot_next;
          R    <= partial_next[WIDTH-1:0];
          done <= 1'b1;
        end
      end
    end
  end

  assign state = state_code(fsm_state);

endmodule

// File: tb/tb_four_bit_divider.sv
// -----------------------------------------------------------------------------
// tb_four_bit_divider
//   Directed self-checking bench for four_bit_divider (WIDTH = 4).
//   Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_four_bit_divider;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [3:0] A, B;
  logic [3:0] Q, R;
  logic       done, div_by_zero, busy;
  logic [3:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  four_bit_divider #(.WIDTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .A           (A),
    .B           (B),
    .Q           (Q),
    .R           (R),
    .done        (done),
    .div_by_zero (div_by_zero),
    .busy        (busy),
    .state       (state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Start one division from IDLE, wait (bounded) for done, check the result
  // and how many edges after the start edge done appeared.
  task automatic run_div(input string tag, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] eq, input logic [3:0] er,
                         input logic edbz, input int elat);
    int n;
    @(negedge clk);
    A = a; B = b; ena = 1'b1;
    @(negedge clk);
    ena = 1'b0;
    n = 0;
    while (!done && n < 12) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, n, elat);
    check({tag, "_Q"}, Q, eq);
    check({tag, "_R"}, R, er);
    check({tag, "_dbz"}, div_by_zero, edbz);
  endtask

  initial begin
    int exp_states [6] = '{1, 1, 1, 1, 2, 0};
    int n;
    logic extra;

    rst = 1'b0; ena = 1'b0; A = '0; B = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_state", state, 0);
    check("rst_Q", Q, 0);
    check("rst_R", R, 0);
    check("rst_done", done, 0);
    check("rst_dbz", div_by_zero, 0);
    check("rst_busy", busy, 0);

    // 13/4 started on the very first edge with reset released
    rst = 1'b1; ena = 1'b1; A = 4'd13; B = 4'd4;
    @(negedge clk);
    ena = 1'b0; A = 4'd2; B = 4'd3;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("seq13_state%0d", i), state, exp_states[i]);
      if (i < 4) check($sformatf("seq13_done%0d", i), done, 0);
      if (i == 0) check("seq13_busy_step", busy, 1);
      if (i == 4) begin
        check("seq13_done", done, 1);
        check("seq13_Q", Q, 3);
        check("seq13_R", R, 1);
        check("seq13_dbz", div_by_zero, 0);
        check("seq13_busy_done", busy, 1);
      end
      if (i == 5) begin
        check("seq13_done_low", done, 0);
        check("seq13_busy_idle", busy, 0);
        check("seq13_Q_hold", Q, 3);
        check("seq13_R_hold", R, 1);
      end
      if (i < 5) @(negedge clk);
    end

    // Boundary operands
    run_div("d15_1", 4'd15, 4'd1, 4'd15, 4'd0, 1'b0, 4);
    run_div("d3_7",  4'd3,  4'd7, 4'd0,  4'd3, 1'b0, 4);
    run_div("d9_0",  4'd9,  4'd0, 4'd15, 4'd9, 1'b1, 0);
    run_div("d8_2",  4'd8,  4'd2, 4'd4,  4'd0, 1'b0, 4);

    // 14/3 with operands changed and ena pulsed during STEP
    @(negedge clk);
    A = 4'd14; B = 4'd3; ena = 1'b1;
    @(negedge clk);
    ena = 1'b0;
    check("d14_in_step", state, 1);
    A = 4'd0; B = 4'd0;
    @(negedge clk);
    ena = 1'b1;
    @(negedge clk);
    ena = 1'b0;
    n = 0;
    while (!done && n < 12) begin
      @(negedge clk);
      n++;
    end
    check("d14_done_seen", done, 1);
    check("d14_Q", Q, 4);
    check("d14_R", R, 2);
    check("d14_dbz", div_by_zero, 0);
    extra = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done || state != 4'd0) extra = 1'b1;
    end
    check("d14_no_second", extra, 0);

    // Reset during the second STEP cycle
    A = 4'd5; B = 4'd2; ena = 1'b1;
    @(negedge clk);
    ena = 1'b0;
    check("mid_rst_step1", state, 1);
    @(negedge clk);
    check("mid_rst_step2", state, 1);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_state", state, 0);
    check("mid_rst_Q", Q, 0);
    check("mid_rst_R", R, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_dbz", div_by_zero, 0);
    check("mid_rst_busy", busy, 0);
    rst = 1'b1;

    // All operand pairs, ena held high: each start lands on the IDLE cycle
    ena = 1'b1;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        logic [3:0] eq, er;
        logic       edbz;
        int         elat;
        A = 4'(a); B = 4'(b);
        if (b == 0) begin
          eq = 4'd15; er = 4'(a); edbz = 1'b1; elat = 0;
        end else begin
          eq = 4'(a / b); er = 4'(a % b); edbz = 1'b0; elat = 4;
        end
        @(negedge clk);
        n = 0;
        while (!done && n < 12) begin
          @(negedge clk);
          n++;
        end
        check($sformatf("ex_%0d_%0d_lat", a, b), n, elat);
        check($sformatf("ex_%0d_%0d_Q", a, b), Q, eq);
        check($sformatf("ex_%0d_%0d_R", a, b), R, er);
        check($sformatf("ex_%0d_%0d_dbz", a, b), div_by_zero, edbz);
        @(negedge clk);
        check($sformatf("ex_%0d_%0d_idle", a, b), state, 0);
      end
    end
    ena = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/four_bit_divider.md
FOUR_BIT_DIVIDER -- requirements
Module: four_bit_divider

Interface
REQ-001 Parameter: WIDTH, default 4, operand/quotient/remainder width; the block SHALL be verified only at 4.
REQ-002 clk  input  1  single clock; all state SHALL change only on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 ena  input  1  start request, sampled only in IDLE.
REQ-005 A  input  WIDTH  dividend, unsigned.
REQ-006 B  input  WIDTH  divisor, unsigned.
REQ-007 Q  output  WIDTH  quotient, registered.
REQ-008 R  output  WIDTH  remainder, registered.
REQ-009 done  output  1  result-valid strobe, registered.
REQ-010 div_by_zero  output  1  error flag for the current result, registered.
REQ-011 busy  output  1  high in STEP and DONE.
REQ-012 state  output  4  current FSM state, zero-extended encoding.

Function
REQ-013 FSM SHALL have exactly three states: IDLE=0, STEP=1, DONE=2.
REQ-014 IDLE with ena=1 at an edge: latch A and B, clear the partial remainder, set step counter to WIDTH-1, go to STEP.
REQ-015 IDLE with ena=1 and B=0 at an edge: go directly to DONE with Q=all-ones, R=A, div_by_zero=1.
REQ-016 STEP: one restoring step per cycle, MSB first: shift the next dividend bit into the partial remainder; if partial >= divisor, subtract and set the quotient bit, else keep partial and clear the bit.
REQ-017 Internal partial remainder SHALL be WIDTH+1 bits so no compare/subtract overflow occurs.
REQ-018 STEP with counter=0 at an edge: load Q and R from the internal registers, go to DONE; otherwise decrement the counter.
REQ-019 Latency: ena sampled at edge k gives done=1 in the cycle after edge k+WIDTH (4 for WIDTH=4); divide-by-zero gives done=1 in the cycle after edge k.
REQ-020 done SHALL be high for exactly one cycle, in DONE only; DONE SHALL return to IDLE unconditionally at the next edge.
REQ-021 Q, R and div_by_zero SHALL hold their values from DONE until the next result is loaded.
REQ-022 div_by_zero SHALL be cleared at every non-zero-divisor start.
REQ-023 ena while busy=1 SHALL be ignored, with no queuing; ena held high SHALL start a new division on the IDLE cycle after DONE.
REQ-024 A and B changing after the start edge SHALL NOT affect the result in progress.
REQ-025 Result SHALL satisfy A = Q*B + R with R < B for every B != 0.

Reset
REQ-026 rst=0 at an edge, in any state including mid-STEP, SHALL force IDLE and clear Q, R, done, div_by_zero, busy, the counter and internal registers to 0.
REQ-027 rst SHALL take priority over ena.
REQ-028 The first start SHALL be accepted at the first edge where rst=1.

Structure
REQ-029 A shared package div_pkg SHALL hold the state enum (IDLE/STEP/DONE), the state width and the divide-by-zero quotient constant.
REQ-030 The FSM and step counter SHALL be one sub-module, div_controller (inputs clk, rst, ena, divisor-zero flag; outputs state and last-step flag).
REQ-031 The datapath (operand registers, shift/subtract, result registers) SHALL live in four_bit_divider.

Verification
REQ-032 A=13, B=4, pulse ena -> done after exactly 4 cycles, Q=3, R=1, div_by_zero=0, state sequence 1,1,1,1,2,0.
REQ-033 A=15, B=1 -> Q=15, R=0; A=3, B=7 -> Q=0, R=3.
REQ-034 A=9, B=0 -> done in the next cycle, Q=15, R=9, div_by_zero=1; then A=8, B=2 -> Q=4, R=0, div_by_zero=0.
REQ-035 Start 14/3, change A/B and pulse ena during STEP -> Q=4, R=2, no second result; assert rst in the 2nd STEP cycle -> state=0, all outputs 0.
REQ-036 Exhaustive 256 A/B pairs with ena held high -> every result matches REQ-025 / REQ-015, with back-to-back starts spaced WIDTH+2 cycles apart.
